// File: rtl/trace_arbiter.sv
// trace_arbiter: merges per-stage trace pulses through per-source FIFOs into one round-robin valid/ready stream
module trace_arbiter #(
   parameter int NUM_SOURCES = 3,
   parameter int FIFO_DEPTH = 4,
   parameter type trace_format = int
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SOURCES-1:0]         src_valid,
   input  trace_format                    src_data [NUM_SOURCES],
   input  logic                           trace_ready,
   input  logic                           clear_overflow,
   output logic                           trace_valid,
   output trace_format                    trace_data,
   output logic [$clog2(NUM_SOURCES)-1:0] trace_src,
   output logic [NUM_SOURCES-1:0]         overflow,
   output logic [15:0]                    drop_count
);
   localparam int SW = $clog2(NUM_SOURCES);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   trace_format mem [NUM_SOURCES][FIFO_DEPTH];
   logic [AW-1:0] rd_ptr [NUM_SOURCES];
   logic [AW-1:0] wr_ptr [NUM_SOURCES];
   logic [CW-1:0] count [NUM_SOURCES];
   logic [SW-1:0] rr_ptr, gnt;
   logic found, load;
   logic [NUM_SOURCES-1:0] pop, push, drop;
   logic [15:0] ndrop;
   logic [16:0] drop_sum;
   always_comb begin
      load = !trace_valid || trace_ready;
      found = 1'b0;
      gnt = '0;
      pop = '0;
      push = '0;
      drop = '0;
      ndrop = '0;
      for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
         int j;
         j = int'(rr_ptr) + k;
         j = (j >= NUM_SOURCES) ? j - NUM_SOURCES : j;
         if (count[j] != '0) begin
            found = 1'b1;
            gnt = SW'(j);
         end
      end
      for (int i = 0; i < NUM_SOURCES; i++) begin
         pop[i] = load && found && gnt == SW'(i);
         push[i] = src_valid[i] && (count[i] != CW'(FIFO_DEPTH) || pop[i]);
         drop[i] = src_valid[i] && !push[i];
         ndrop = ndrop + 16'(drop[i]);
      end
      drop_sum = {1'b0, clear_overflow ? 16'h0 : drop_count} + {1'b0, ndrop};
   end
   always_ff @(posedge clk)
      for (int i = 0; i < NUM_SOURCES; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= src_data[i];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         trace_valid <= 1'b0;
         trace_data <= '0;
         trace_src <= '0;
         overflow <= '0;
         drop_count <= '0;
         rr_ptr <= '0;
         for (int i = 0; i < NUM_SOURCES; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i] <= '0;
         end
      end else begin
         if (load) begin
            trace_valid <= found;
            if (found) begin
               trace_data <= mem[gnt][rd_ptr[gnt]];
               trace_src <= gnt;
               rr_ptr <= (gnt == SW'(NUM_SOURCES - 1)) ? '0 : gnt + 1'b1;
            end
         end
         for (int i = 0; i < NUM_SOURCES; i++) begin
            rd_ptr[i] <= rd_ptr[i] + AW'(pop[i]);
            wr_ptr[i] <= wr_ptr[i] + AW'(push[i]);
            count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
         end
         overflow <= (clear_overflow ? '0 : overflow) | drop;
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
endmodule

// File: tb/tb_trace_arbiter.sv
// tb_trace_arbiter: queue-based reference model feeding a scoreboard checked by a separate output monitor
module tb_trace_arbiter;
   localparam int N = 3;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] src_valid = '0;
   int src_data [N];
   logic trace_ready = 1'b0;
   logic clear_overflow = 1'b0;
   logic trace_valid;
   int trace_data;
   logic [1:0] trace_src;
   logic [N-1:0] overflow;
   logic [15:0] drop_count;
   int errors = 0;
   int checks = 0;
   int q [N][$];
   int sbd [$];
   int sbs [$];
   bit mvalid;
   int rr;
   logic [N-1:0] movf;
   int mdrop;
   bit pv;
   int pd;
   logic [1:0] ps;
   int a;
   always #5 clk = ~clk;
   trace_arbiter #(.NUM_SOURCES(N), .FIFO_DEPTH(D), .trace_format(int)) dut (
      .clk(clk),
      .rst(rst),
      .src_valid(src_valid),
      .src_data(src_data),
      .trace_ready(trace_ready),
      .clear_overflow(clear_overflow),
      .trace_valid(trace_valid),
      .trace_data(trace_data),
      .trace_src(trace_src),
      .overflow(overflow),
      .drop_count(drop_count)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic mclear();
      for (int i = 0; i < N; i++) q[i].delete();
      sbd.delete();
      sbs.delete();
      mvalid = 0;
      rr = 0;
      movf = '0;
      mdrop = 0;
   endtask
   // one rising edge of the abstract arbiter: serve the output, then accept or drop arrivals
   task automatic model_edge();
      int g;
      int nd;
      g = -1;
      nd = 0;
      if (!mvalid || trace_ready) begin
         for (int k = 0; k < N; k++)
            if (g < 0 && q[(rr + k) % N].size() > 0) g = (rr + k) % N;
         mvalid = (g >= 0);
         if (g >= 0) begin
            sbd.push_back(q[g].pop_front());
            sbs.push_back(g);
            rr = (g + 1) % N;
         end
      end
      if (clear_overflow) begin
         movf = '0;
         mdrop = 0;
      end
      for (int i = 0; i < N; i++)
         if (src_valid[i]) begin
            if (q[i].size() < D) q[i].push_back(src_data[i]);
            else begin
               movf[i] = 1'b1;
               nd++;
            end
         end
      mdrop = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
   endtask
   task automatic tick(input logic [N-1:0] v, input logic rdy, input logic clr = 1'b0);
      src_valid = v;
      for (int i = 0; i < N; i++) src_data[i] = int'($urandom);
      trace_ready = rdy;
      clear_overflow = clr;
      @(posedge clk);
      model_edge();
      #1;
      chk("valid", 32'(trace_valid), 32'(mvalid));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("drop_count", 32'(drop_count), mdrop);
      src_valid = '0;
      clear_overflow = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      src_valid = '0;
      trace_ready = 1'b0;
      clear_overflow = 1'b0;
      mclear();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask
   always @(negedge clk) begin
      if (rst) pv = 0;
      else begin
         if (pv) begin
            chk("hold_valid", 32'(trace_valid), 32'd1);
            chk("hold_data", trace_data, pd);
            chk("hold_src", 32'(trace_src), 32'(ps));
         end
         pv = trace_valid && !trace_ready;
         pd = trace_data;
         ps = trace_src;
         if (trace_valid && trace_ready) begin
            if (sbd.size() == 0) chk("sb_underflow", 32'(sbd.size()), 32'd1);
            else begin
               chk("data", trace_data, sbd.pop_front());
               chk("src", 32'(trace_src), sbs.pop_front());
            end
         end
      end
   end
   initial begin
      for (int i = 0; i < N; i++) src_data[i] = 0;
      mclear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(trace_valid), 32'd0);
      chk("rst_data", trace_data, 32'd0);
      chk("rst_src", 32'(trace_src), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      rst = 1'b0;
      tick(3'b001, 1'b1);
      a = src_data[0];
      chk("if_no_bypass", 32'(trace_valid), 32'd0);
      tick(3'b000, 1'b1);
      chk("if_valid", 32'(trace_valid), 32'd1);
      chk("if_data", trace_data, a);
      chk("if_src", 32'(trace_src), 32'd0);
      tick(3'b000, 1'b1);
      chk("if_done", 32'(trace_valid), 32'd0);
      do_reset();
      tick(3'b111, 1'b0);
      tick(3'b000, 1'b0);
      chk("rr_first", 32'(trace_src), 32'd0);
      tick(3'b000, 1'b1);
      chk("rr_second", 32'(trace_src), 32'd1);
      tick(3'b000, 1'b1);
      chk("rr_third", 32'(trace_src), 32'd2);
      tick(3'b000, 1'b1);
      chk("rr_empty", 32'(trace_valid), 32'd0);
      tick(3'b001, 1'b0);
      chk("rr_wrapped", 32'(trace_valid), 32'd0);
      tick(3'b000, 1'b0);
      chk("rr_wrap_src", 32'(trace_src), 32'd0);
      tick(3'b000, 1'b1);
      tick(3'b010, 1'b0);
      repeat (5) tick(3'b000, 1'b0);
      tick(3'b000, 1'b1);
      tick(3'b000, 1'b1);
      chk("bp_once", 32'(trace_valid), 32'd0);
      do_reset();
      repeat (6) tick(3'b010, 1'b0);
      chk("ovf_flag", 32'(overflow), 32'b010);
      chk("ovf_count", 32'(drop_count), 32'd1);
      repeat (8) tick(3'b000, 1'b1);
      repeat (11) tick(3'b100, 1'b0);
      chk("clr_pre", 32'(drop_count), 32'd7);
      tick(3'b100, 1'b0, 1'b1);
      chk("clr_flag", 32'(overflow), 32'b100);
      chk("clr_count", 32'(drop_count), 32'd1);
      repeat (22000) tick(3'b111, 1'b0);
      chk("sat_count", 32'(drop_count), 32'hFFFF);
      tick(3'b000, 1'b0, 1'b1);
      chk("sat_clear", 32'(drop_count), 32'd0);
      repeat (16) tick(3'b000, 1'b1);
      tick(3'b111, 1'b0);
      tick(3'b001, 1'b0);
      tick(3'b000, 1'b1);
      tick(3'b000, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(trace_valid), 32'd0);
      chk("arst_data", trace_data, 32'd0);
      chk("arst_src", 32'(trace_src), 32'd0);
      chk("arst_overflow", 32'(overflow), 32'd0);
      mclear();
      @(negedge clk);
      #1 rst = 1'b0;
      tick(3'b110, 1'b1);
      tick(3'b000, 1'b1);
      chk("arst_new_valid", 32'(trace_valid), 32'd1);
      chk("arst_new_src", 32'(trace_src), 32'd1);
      repeat (500) tick(N'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      repeat (25) tick(3'b000, 1'b1);
      chk("sb_empty", 32'(sbd.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
